// File: rtl/mfu_fusion_mult_if.sv
// Operand/result bundle for the fusion multiply unit.
// Master drives a, b and mode; the multiply unit (slave) drives p.
interface mfu_fusion_mult_if;
    logic        [7:0]  a;
    logic        [7:0]  b;
    logic        [1:0]  mode;
    logic signed [15:0] p;

    modport master (
        output a,
        output b,
        output mode,
        input  p
    );

    modport slave (
        input  a,
        input  b,
        input  mode,
        output p
    );
endinterface

// File: rtl/mfu_fusion_mult.sv
// Multi-precision signed multiply (8x8, 2-lane 4x4 dot, 4-lane 2x2 dot).
// Ports: clk, nrst (async active-low), bus.slave {a, b, mode in; p out, registered}.
module mfu_fusion_mult (
    input  logic                clk,
    input  logic                nrst,
    mfu_fusion_mult_if.slave    bus
);

    logic signed [15:0] a_ext;
    logic signed [15:0] b_ext;
    logic signed [15:0] prod8;
    logic signed [15:0] lane_a;
    logic signed [15:0] lane_b;
    logic signed [15:0] dot4;
    logic signed [15:0] dot2;
    logic signed [15:0] p_d;
    logic signed [15:0] p_q;

    // Everything is done at 16 bits: each product's true value fits,
    // so the low 16 bits of the wide products are exact.
    always_comb begin
        a_ext  = {{8{bus.a[7]}}, bus.a};
        b_ext  = {{8{bus.b[7]}}, bus.b};
        prod8  = a_ext * b_ext;

        lane_a = '0;
        lane_b = '0;

        dot4 = '0;
        for (int i = 0; i < 2; i++) begin
            lane_a = {{12{bus.a[4*i+3]}}, bus.a[4*i +: 4]};
            lane_b = {{12{bus.b[4*i+3]}}, bus.b[4*i +: 4]};
            dot4   = dot4 + lane_a * lane_b;
        end

        dot2 = '0;
        for (int i = 0; i < 4; i++) begin
            lane_a = {{14{bus.a[2*i+1]}}, bus.a[2*i +: 2]};
            lane_b = {{14{bus.b[2*i+1]}}, bus.b[2*i +: 2]};
            dot2   = dot2 + lane_a * lane_b;
        end

        case (bus.mode)
            2'd0:    p_d = prod8;
            2'd1:    p_d = dot4;
            2'd2:    p_d = dot2;
            default: p_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign bus.p = p_q;

endmodule

// File: tb/tb_mfu_fusion_mult.sv
// Self-checking bench for mfu_fusion_mult.
// Directed literal vectors plus random vectors against an integer model.
module tb_mfu_fusion_mult;

    logic clk;
    logic nrst;
    logic run_cmp;
    int   checks;
    int   errors;
    logic [15:0] exp_q;

    mfu_fusion_mult_if bus ();

    mfu_fusion_mult dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sval(input int raw, input int bits);
        int v;
        v = raw & ((1 << bits) - 1);
        if (v >= (1 << (bits - 1))) v = v - (1 << bits);
        return v;
    endfunction

    // Reference: split each operand into signed lanes and sum products.
    function automatic logic [15:0] ref_p(input logic [1:0] m,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        int w;
        int n;
        int acc;
        case (m)
            2'd0: w = 8;
            2'd1: w = 4;
            2'd2: w = 2;
            default: return 16'd0;
        endcase
        n   = 8 / w;
        acc = 0;
        for (int k = 0; k < n; k++) begin
            acc += sval(int'(a) >> (k * w), w) * sval(int'(b) >> (k * w), w);
        end
        return 16'(acc);
    endfunction

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t",
                     nm, $signed(act), act, $signed(expv), expv, $time);
        end
    endtask

    // Expected register: loads the model value at every edge, clears on reset.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) exp_q <= 16'd0;
        else       exp_q <= ref_p(bus.mode, bus.a, bus.b);
    end

    always @(negedge clk) begin
        if (run_cmp) chk("model", bus.p, exp_q);
    end

    // Called on a falling edge: drive inputs, check p one cycle later.
    task automatic vec(input logic [1:0] m, input logic [7:0] a,
                       input logic [7:0] b, input int expv,
                       input string nm);
        bus.mode = m;
        bus.a    = a;
        bus.b    = b;
        @(negedge clk);
        chk(nm, bus.p, 16'(expv));
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        run_cmp  = 1'b0;
        nrst     = 1'b0;
        bus.a    = 8'd5;
        bus.b    = 8'd7;
        bus.mode = 2'd0;
        #1;
        run_cmp = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold", bus.p, 16'd0);
        end
        nrst = 1'b1;
        @(negedge clk);
        chk("rst_release", bus.p, 16'd35);

        #2 nrst = 1'b0;
        #1 chk("rst_async", bus.p, 16'd0);
        @(negedge clk);
        nrst = 1'b1;

        vec(2'd0, 8'h80, 8'h80, 16384,  "m0_min_min");
        vec(2'd0, 8'h7F, 8'h80, -16256, "m0_max_min");
        vec(2'd0, 8'hFF, 8'hFF, 1,      "m0_neg1");
        vec(2'd0, 8'h00, 8'hB3, 0,      "m0_zero");
        vec(2'd1, 8'h78, 8'h88, 8,      "m1_78_88");
        vec(2'd1, 8'h88, 8'h88, 128,    "m1_88_88");
        vec(2'd1, 8'h7F, 8'h11, 6,      "m1_7f_11");
        vec(2'd2, 8'hAA, 8'hAA, 16,     "m2_aa_aa");
        vec(2'd2, 8'h55, 8'hAA, -8,     "m2_55_aa");
        vec(2'd2, 8'h1B, 8'hFF, 2,      "m2_1b_ff");

        vec(2'd0, 8'd10,  8'hFD, -30, "b2b_m0");
        vec(2'd1, 8'h78,  8'h88, 8,   "b2b_m1");
        vec(2'd2, 8'hAA,  8'hAA, 16,  "b2b_m2");
        vec(2'd3, 8'd50,  8'd50, 0,   "b2b_m3");

        for (int i = 0; i < 1000; i++) begin
            bus.mode = 2'($urandom_range(0, 3));
            bus.a    = 8'($urandom);
            bus.b    = 8'($urandom);
            @(negedge clk);
        end
        @(negedge clk);
        run_cmp = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
